uart_tx_fifo_drain: RTL and testbench

Downstream consumer of the generic FIFO. It pops one word at a time through the FIFO's read/empty/read_data interface and serialises each word onto a UART TX line: start bit, data LSB first, optional parity, then stop bit(s). It sits between the FIFO and the chip's serial output pin and runs with no software involvement once `enable` is high.

---
 rtl/uart_tx_fifo_drain.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - pops words from a FIFO and serialises them onto a UART TX line
`timescale 1ns/1ps
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_read_data_i,
  output logic                  fifo_read_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  byte_done_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tx_q, tx_d;
  logic                  baud_end, stop_last;

  assign baud_end  = (baud_q == BAUD_LAST);
  // stop_cnt_q marks the second stop bit; with one stop bit every stop bit is the last
  assign stop_last = (STOP_BITS < 2) || stop_cnt_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    parity_d   = parity_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      S_IDLE:  if (enable_i && !fifo_empty_i) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d    = fifo_read_data_i;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        parity_d   = (^fifo_read_data_i) ^ (PARITY_ODD != 0);
        state_d    = S_START;
      end
      S_START: if (baud_end) state_d = S_DATA;
      S_DATA: begin
        if (baud_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (baud_end) state_d = S_STOP;
      S_STOP: begin
        if (baud_end) begin
          if (stop_last) state_d = S_IDLE;
          else           stop_cnt_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) baud_d = '0;
    else if (baud_end)      baud_d = '0;
    else                    baud_d = baud_q + BAUD_W'(1);

    // tx is computed from next state so the registered line changes on the state edge
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = (state_q != S_IDLE);
  assign fifo_read_o = (state_q == S_FETCH);
  assign byte_done_o = (state_q == S_STOP) && baud_end && stop_last;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - directed vector bench for uart_tx_fifo_drain
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       fifo_empty, fifo_read, tx, busy, byte_done;
  logic [7:0] fifo_rdata;
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  logic [1:0] p_empty, p_rd, p_tx, p_busy, p_bd;
  logic [7:0] pw;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] word;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl [5];
  logic [9:0] b2b_exp [3];

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_rdata <= mem[rd_ptr % 64];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .fifo_empty_i(fifo_empty), .fifo_read_data_i(fifo_rdata),
    .fifo_read_o(fifo_read), .tx_o(tx), .busy_o(busy), .byte_done_o(byte_done)
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
                       .PARITY_ODD(0), .STOP_BITS(2)) u_par_even (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .fifo_empty_i(p_empty[0]), .fifo_read_data_i(pw),
    .fifo_read_o(p_rd[0]), .tx_o(p_tx[0]), .busy_o(p_busy[0]), .byte_done_o(p_bd[0])
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
                       .PARITY_ODD(1), .STOP_BITS(1)) u_par_odd (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .fifo_empty_i(p_empty[1]), .fifo_read_data_i(pw),
    .fifo_read_o(p_rd[1]), .tx_o(p_tx[1]), .busy_o(p_busy[1]), .byte_done_o(p_bd[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Expects DUT idle with enable high and a word waiting; returns in the idle cycle after the frame
  task automatic check_frame(input logic [9:0] exp, input string nm);
    int bad_tx = 0;
    int bad_ctl = 0;
    int bd_at = -1;
    int bd_cnt = 0;
    @(negedge clk);
    chk({nm, " fetch"}, 32'({fifo_read, busy}), 32'b11);
    @(negedge clk);
    chk({nm, " load"}, 32'({fifo_read, busy, tx}), 32'b011);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== exp[i / 4]) bad_tx++;
      if (busy !== 1'b1 || fifo_read !== 1'b0) bad_ctl++;
      if (byte_done === 1'b1) begin
        bd_cnt++;
        if (bd_at < 0) bd_at = i;
      end
    end
    chk({nm, " tx bits"}, bad_tx, 0);
    chk({nm, " busy/read during frame"}, bad_ctl, 0);
    chk({nm, " byte_done cycle"}, bd_at, 39);
    chk({nm, " byte_done pulses"}, bd_cnt, 1);
    @(negedge clk);
    chk({nm, " idle after"}, 32'({busy, tx, byte_done, fifo_read}), 32'b0100);
  endtask

  task automatic wait_start(input string nm);
    int t = 0;
    while (tx !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " start latency"}, t, 3);
  endtask

  task automatic par_check(input int k, input logic exp_par, input int exp_len, input string nm);
    int t = 0;
    int i = 0;
    int bad = 0;
    logic par_seen = 1'bx;
    logic etx;
    p_empty[k] = 1'b0;
    while (p_rd[k] !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " fetch latency"}, t, 1);
    p_empty[k] = 1'b1;
    t = 0;
    while (p_tx[k] !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " start latency"}, t, 2);
    while (p_bd[k] !== 1'b1 && i < 100) begin
      if (i < 4)       etx = 1'b0;
      else if (i < 36) etx = pw[(i - 4) / 4];
      else if (i < 40) etx = exp_par;
      else             etx = 1'b1;
      if (p_tx[k] !== etx) bad++;
      if (i == 37) par_seen = p_tx[k];
      @(negedge clk);
      i++;
    end
    chk({nm, " parity bit"}, 32'(par_seen), 32'(exp_par));
    chk({nm, " frame bits"}, bad, 0);
    chk({nm, " frame length"}, i + 1, exp_len);
    chk({nm, " stop level at done"}, 32'(p_tx[k]), 32'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r, bad_tx, bad_busy, bad_bd, c;
    logic etx;

    tbl[0] = '{word: 8'hA5, exp: 10'h34A};
    tbl[1] = '{word: 8'h00, exp: 10'h200};
    tbl[2] = '{word: 8'hFF, exp: 10'h3FE};
    tbl[3] = '{word: 8'h3C, exp: 10'h278};
    tbl[4] = '{word: 8'h07, exp: 10'h20E};
    b2b_exp[0] = 10'h200;
    b2b_exp[1] = 10'h3FE;
    b2b_exp[2] = 10'h278;
    pw = 8'h07;

    rst_n   = 1'b0;
    enable  = 1'b0;
    p_empty = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset main", 32'({tx, busy, byte_done, fifo_read}), 32'b1000);
    chk("reset parity", 32'({p_tx, p_busy, p_bd, p_rd}), 32'b11_00_00_00);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    for (int v = 0; v < 5; v++) begin
      push(tbl[v].word);
      check_frame(tbl[v].exp, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d fifo drained", v), 32'(fifo_empty), 32'b1);
    end

    // Back-to-back: three queued words, 43-cycle word period
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_start("b2b");
    bad_tx = 0; bad_busy = 0; bad_bd = 0;
    for (int i = 0; i < 126; i++) begin
      if (i > 0) @(negedge clk);
      k = i / 43;
      r = i % 43;
      etx = (r < 40) ? b2b_exp[k][r / 4] : 1'b1;
      if (tx !== etx) bad_tx++;
      if (busy !== (r != 40)) bad_busy++;
      if (byte_done !== (r == 39)) bad_bd++;
    end
    chk("b2b tx stream", bad_tx, 0);
    chk("b2b busy gaps", bad_busy, 0);
    chk("b2b byte_done spacing", bad_bd, 0);
    @(negedge clk);
    chk("b2b idle after", 32'({busy, tx, fifo_empty}), 32'b011);

    // Enable dropped during DATA of the first of two words
    push(8'h5A);
    push(8'hA5);
    wait_start("gate");
    repeat (12) @(negedge clk);
    enable = 1'b0;
    c = 12;
    while (byte_done !== 1'b1 && c < 80) begin
      @(negedge clk);
      c++;
    end
    chk("gate frame1 byte_done cycle", c, 39);
    bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_read !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad_busy++;
    end
    chk("gate no fetch while disabled", bad_busy, 0);
    chk("gate word retained", 32'(fifo_empty), 32'b0);
    enable = 1'b1;
    check_frame(10'h34A, "gate frame2");

    // Empty FIFO with enable high
    bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_read !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad_busy++;
    end
    chk("empty fifo idle", bad_busy, 0);

    // Reset mid-frame during data bit 3 of 0xA5
    push(8'hA5);
    push(8'h3C);
    wait_start("rst");
    repeat (17) @(negedge clk);
    chk("rst pre tx low", 32'(tx), 32'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst immediate", 32'({tx, busy, fifo_read, byte_done}), 32'b1000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(10'h278, "post-reset");

    // Parity variants on 0x07
    par_check(0, 1'b1, 48, "even2stop");
    @(negedge clk);
    par_check(1, 1'b0, 44, "odd1stop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
